// File: rtl/sensor_frame_gen_if.sv
// Pattern stream bundle for sensor_frame_gen.
// Carries AXI-Stream style pattern words from a pattern source to the frame generator.
//   tdata  : one pattern word, replicated across the LVDS bus by the consumer
//   tvalid : source has a word ready
//   tready : consumer strobe; one cycle long, issued in the first frame cycle
// Modports:
//   master : pattern source (drives tdata/tvalid, observes tready)
//   slave  : frame generator (observes tdata/tvalid, drives tready)
interface sensor_frame_gen_if #(
  parameter int PATTERN_WIDTH = 32
);
  logic [PATTERN_WIDTH-1:0] tdata;
  logic                     tvalid;
  logic                     tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/sensor_frame_gen.sv
// Sensor emulator producing a periodic sync pulse, an alternating idle byte
// pattern and, on an rs0/rs256 request inside the sync window, one data frame
// of cycles_per_frame cycles on the LVDS bus.
// Ports:
//   clk, reset         : sole clock, asynchronous active-high reset
//   enable             : gates pa_sync only
//   rs0, rs256         : frame-start requests (ORed)
//   cycles_per_frame   : frame length, sampled when a frame starts (minimum 3)
//   idle_0, idle_1     : idle bytes replicated across the bus
//   frame_header       : replaces the top 32 bits during the first frame cycle
//   ramp_mode          : frame data is the frame number instead of a stream word
//   pa_sync            : periodic sync pulse
//   lvds, sof, eof     : data bus plus first/last frame cycle flags
//   frame_count        : frames started since reset
//   underrun_count     : saturating count of starts with no pattern available
//   pattern            : pattern stream (slave side)
module sensor_frame_gen #(
  parameter int LVDS_WIDTH        = 512,
  parameter int PATTERN_WIDTH     = 32,
  parameter int SYNC_PERIOD_LOG2  = 8,
  parameter int SYNC_PULSE_LENGTH = 4,
  parameter int TRIGGER_WINDOW    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  rs0,
  input  logic                  rs256,
  input  logic [31:0]           cycles_per_frame,
  input  logic [7:0]            idle_0,
  input  logic [7:0]            idle_1,
  input  logic [31:0]           frame_header,
  input  logic                  ramp_mode,
  output logic                  pa_sync,
  output logic [LVDS_WIDTH-1:0] lvds,
  output logic                  sof,
  output logic                  eof,
  output logic [31:0]           frame_count,
  output logic [15:0]           underrun_count,
  sensor_frame_gen_if.slave     pattern
);

  localparam int PATTERN_REPS = LVDS_WIDTH / PATTERN_WIDTH;
  localparam int BYTE_REPS    = LVDS_WIDTH / 8;
  localparam logic [SYNC_PERIOD_LOG2-1:0] PULSE_LIMIT  = SYNC_PERIOD_LOG2'(SYNC_PULSE_LENGTH);
  localparam logic [SYNC_PERIOD_LOG2-1:0] WINDOW_LIMIT = SYNC_PERIOD_LOG2'(TRIGGER_WINDOW);
  localparam logic [31:0] MIN_FRAME = 32'd3;

  typedef enum logic [5:0] {
    ST_RESET = 6'b000001,
    ST_IDLE0 = 6'b000010,
    ST_IDLE1 = 6'b000100,
    ST_FC    = 6'b001000,
    ST_DC    = 6'b010000,
    ST_LC    = 6'b100000
  } state_t;

  state_t                      state_q, state_d;
  logic [SYNC_PERIOD_LOG2-1:0] free_timer_q, free_timer_d;
  logic [31:0]                 cyc_q, cyc_d;
  logic [31:0]                 cpf_eff_q, cpf_eff_d;
  logic [31:0]                 frame_count_q, frame_count_d;
  logic [15:0]                 underrun_q, underrun_d;
  logic [LVDS_WIDTH-1:0]       cell_data_q, cell_data_d;
  logic                        tready_q, tready_d;
  logic                        trig;
  logic                        accept;
  logic [31:0]                 frame_next;
  logic [PATTERN_WIDTH-1:0]    ramp_word;

  // rs0 and rs256 together still count as a single request.
  assign trig       = (rs0 | rs256) & (free_timer_q < WINDOW_LIMIT);
  assign pa_sync    = enable & ~reset & (free_timer_q < PULSE_LIMIT);
  assign frame_next = frame_count_q + 32'd1;
  assign ramp_word  = PATTERN_WIDTH'(frame_next);

  assign frame_count    = frame_count_q;
  assign underrun_count = underrun_q;
  assign pattern.tready = tready_q;

  // Next-state logic. A new frame can only start from IDLE1 or from LC, which
  // gives back-to-back frames without an idle gap; requests anywhere else are dropped.
  always_comb begin
    state_d       = state_q;
    free_timer_d  = free_timer_q + SYNC_PERIOD_LOG2'(1);
    cyc_d         = cyc_q;
    cpf_eff_d     = cpf_eff_q;
    frame_count_d = frame_count_q;
    underrun_d    = underrun_q;
    cell_data_d   = cell_data_q;
    tready_d      = 1'b0;
    accept        = 1'b0;

    unique case (state_q)
      ST_RESET: state_d = ST_IDLE0;
      ST_IDLE0: state_d = ST_IDLE1;
      ST_IDLE1: begin
        if (trig) accept = 1'b1;
        else      state_d = ST_IDLE0;
      end
      ST_FC: begin
        state_d = ST_DC;
        cyc_d   = cyc_q + 32'd1;
      end
      ST_DC: begin
        cyc_d = cyc_q + 32'd1;
        if (cyc_q >= cpf_eff_q - 32'd1) state_d = ST_LC;
      end
      ST_LC: begin
        if (trig) accept = 1'b1;
        else      state_d = ST_IDLE0;
      end
      default: state_d = ST_RESET;
    endcase

    // Frame length is latched here so mid-frame changes on cycles_per_frame are harmless.
    if (accept) begin
      state_d       = ST_FC;
      cyc_d         = 32'd1;
      cpf_eff_d     = (cycles_per_frame < MIN_FRAME) ? MIN_FRAME : cycles_per_frame;
      frame_count_d = frame_next;
      if (ramp_mode) begin
        cell_data_d = {PATTERN_REPS{ramp_word}};
      end else if (pattern.tvalid) begin
        cell_data_d = {PATTERN_REPS{pattern.tdata}};
        tready_d    = 1'b1;
      end else if (underrun_q != 16'hFFFF) begin
        underrun_d = underrun_q + 16'd1;
      end
    end
  end

  // State registers; reset puts every output back to its idle value at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RESET;
      free_timer_q  <= '0;
      cyc_q         <= '0;
      cpf_eff_q     <= MIN_FRAME;
      frame_count_q <= '0;
      underrun_q    <= '0;
      cell_data_q   <= '0;
      tready_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      free_timer_q  <= free_timer_d;
      cyc_q         <= cyc_d;
      cpf_eff_q     <= cpf_eff_d;
      frame_count_q <= frame_count_d;
      underrun_q    <= underrun_d;
      cell_data_q   <= cell_data_d;
      tready_q      <= tready_d;
    end
  end

  // Bus contents follow the state directly. The first frame cycle carries the
  // header in its top word and the last carries the frame number in its bottom word.
  always_comb begin
    lvds = '0;
    sof  = 1'b0;
    eof  = 1'b0;
    unique case (state_q)
      ST_IDLE0: lvds = {BYTE_REPS{idle_0}};
      ST_IDLE1: lvds = {BYTE_REPS{idle_1}};
      ST_FC: begin
        lvds = {frame_header, cell_data_q[LVDS_WIDTH-33:0]};
        sof  = 1'b1;
      end
      ST_DC: lvds = cell_data_q;
      ST_LC: begin
        lvds = {cell_data_q[LVDS_WIDTH-1:32], frame_count_q};
        eof  = 1'b1;
      end
      default: lvds = '0;
    endcase
  end

endmodule

// File: tb/tb_sensor_frame_gen.sv
// Testbench for sensor_frame_gen. Stimulus pushes one expected-frame record per
// requested frame; an independent monitor pops a record at every sof and
// compares each frame cycle against it.
module tb_sensor_frame_gen;

  localparam int LW = 512;
  localparam int PW = 32;

  typedef struct {
    logic [31:0] header;
    logic [31:0] word;
    int          length;
    logic [31:0] frame_no;
    logic [15:0] underrun;
    bit          tready;
    bit          back_to_back;
  } frame_exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable, rs0, rs256, ramp_mode;
  logic [31:0]   cycles_per_frame, frame_header;
  logic [7:0]    idle_0, idle_1;
  logic          pa_sync, sof, eof;
  logic [LW-1:0] lvds;
  logic [31:0]   frame_count;
  logic [15:0]   underrun_count;

  int          n_checks = 0;
  int          n_fails  = 0;
  frame_exp_t  exp_q[$];
  logic [31:0] exp_frames;
  logic [15:0] exp_underrun;
  logic [31:0] last_word;
  logic [7:0]  ft_model;

  bit          in_frame = 1'b0;
  bit          prev_eof = 1'b0;
  int          cyc = 0;
  frame_exp_t  cur;

  sensor_frame_gen_if #(.PATTERN_WIDTH(PW)) pattern_bus ();

  sensor_frame_gen #(
    .LVDS_WIDTH(LW), .PATTERN_WIDTH(PW), .SYNC_PERIOD_LOG2(8),
    .SYNC_PULSE_LENGTH(4), .TRIGGER_WINDOW(2)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .rs0(rs0), .rs256(rs256),
    .cycles_per_frame(cycles_per_frame), .idle_0(idle_0), .idle_1(idle_1),
    .frame_header(frame_header), .ramp_mode(ramp_mode), .pa_sync(pa_sync),
    .lvds(lvds), .sof(sof), .eof(eof), .frame_count(frame_count),
    .underrun_count(underrun_count), .pattern(pattern_bus)
  );

  always #5 clk = ~clk;

  // Free-running timer reference used only to place requests inside or outside the window.
  always @(posedge clk or posedge reset) begin
    if (reset) ft_model <= 8'd0;
    else       ft_model <= ft_model + 8'd1;
  end

  function automatic logic [LW-1:0] rep8(input logic [7:0] b);
    return {(LW/8){b}};
  endfunction

  task automatic checkOutput(input string name, input logic [LW-1:0] actual, input logic [LW-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic waitFt(input logic [7:0] target);
    bit hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      hit = (ft_model == target);
    end
    if (!hit) begin
      n_checks++;
      n_fails++;
      $display("[TB] FAIL wait_timer: timer %0d, required %0d", ft_model, target);
    end
  endtask

  task automatic checkIdle(input string name);
    logic [LW-1:0] a, b;
    @(negedge clk);
    a = lvds;
    @(negedge clk);
    b = lvds;
    checkOutput(name, LW'(((a == rep8(idle_0)) && (b == rep8(idle_1))) ||
                          ((a == rep8(idle_1)) && (b == rep8(idle_0)))), LW'(1));
  endtask

  task automatic countSync(input logic en, output int cnt);
    enable = en;
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (pa_sync) cnt++;
    end
  endtask

  task automatic resetChecks(input string tag);
    checkOutput({tag, "_lvds"}, lvds, LW'(0));
    checkOutput({tag, "_sof_eof"}, LW'({sof, eof}), LW'(0));
    checkOutput({tag, "_frame_count"}, LW'(frame_count), LW'(0));
    checkOutput({tag, "_underrun"}, LW'(underrun_count), LW'(0));
    checkOutput({tag, "_tready"}, LW'(pattern_bus.tready), LW'(0));
    checkOutput({tag, "_pa_sync"}, LW'(pa_sync), LW'(0));
  endtask

  // Holds the request across n_frames consecutive trigger windows and records
  // the frame each accepted request should produce.
  task automatic applyStimulus(input int n_frames, input bit use_rs256, input logic [31:0] cpf,
                               input logic [31:0] data, input bit valid, input bit ramp);
    frame_exp_t e;
    int len = (cpf < 32'd3) ? 3 : int'(cpf);
    waitFt(8'd255);
    cycles_per_frame   = cpf;
    ramp_mode          = ramp;
    pattern_bus.tdata  = data;
    pattern_bus.tvalid = valid;
    if (use_rs256) rs256 = 1'b1;
    else           rs0   = 1'b1;
    for (int f = 0; f < n_frames; f++) begin
      exp_frames     = exp_frames + 32'd1;
      e.header       = frame_header;
      e.length       = len;
      e.frame_no     = exp_frames;
      e.back_to_back = (f > 0);
      if (ramp) begin
        e.word    = exp_frames;
        e.tready  = 1'b0;
        last_word = exp_frames;
      end else if (valid) begin
        e.word    = data;
        e.tready  = 1'b1;
        last_word = data;
      end else begin
        e.word   = last_word;
        e.tready = 1'b0;
        if (exp_underrun != 16'hFFFF) exp_underrun = exp_underrun + 16'd1;
      end
      e.underrun = exp_underrun;
      exp_q.push_back(e);
      waitFt(8'd2);
    end
    rs0   = 1'b0;
    rs256 = 1'b0;
    waitFt(8'd3);
    pattern_bus.tvalid = 1'b0;
  endtask

  // Monitor: pops an expected frame at every sof and checks each frame cycle.
  initial begin
    logic [LW-1:0] wide, exp_lvds;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        in_frame = 1'b0;
        prev_eof = 1'b0;
        exp_q.delete();
      end else begin
        if (!in_frame && sof && exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          in_frame = 1'b1;
          cyc = 0;
          checkOutput("sof_gap", LW'(prev_eof), LW'(cur.back_to_back));
        end
        if (in_frame) begin
          cyc++;
          wide = {(LW/PW){cur.word}};
          if (cyc == 1)               exp_lvds = {cur.header, wide[LW-33:0]};
          else if (cyc == cur.length) exp_lvds = {wide[LW-1:32], cur.frame_no};
          else                        exp_lvds = wide;
          checkOutput("frame_lvds", lvds, exp_lvds);
          checkOutput("frame_sof", LW'(sof), LW'(cyc == 1));
          checkOutput("frame_eof", LW'(eof), LW'(cyc == cur.length));
          checkOutput("frame_tready", LW'(pattern_bus.tready), LW'((cyc == 1) && cur.tready));
          if (cyc == cur.length) begin
            checkOutput("frame_count", LW'(frame_count), LW'(cur.frame_no));
            checkOutput("underrun_count", LW'(underrun_count), LW'(cur.underrun));
            in_frame = 1'b0;
          end
        end else begin
          checkOutput("idle_flags", LW'({sof, eof, pattern_bus.tready}), LW'(0));
        end
        prev_eof = eof;
      end
    end
  end

  initial begin
    int cnt;
    rs0 = 1'b0; rs256 = 1'b0; enable = 1'b0; ramp_mode = 1'b0;
    cycles_per_frame = 32'd8; frame_header = 32'hF00D_0001;
    idle_0 = 8'h3C; idle_1 = 8'hC3;
    pattern_bus.tdata = '0; pattern_bus.tvalid = 1'b0;
    exp_frames = 32'd0; exp_underrun = 16'd0; last_word = 32'd0;

    repeat (3) @(negedge clk);
    enable = 1'b1;
    #1;
    resetChecks("reset");
    reset = 1'b0;

    checkIdle("idle_alternation");
    countSync(1'b1, cnt);
    checkOutput("pa_sync_enabled_count", LW'(cnt), LW'(4));
    countSync(1'b0, cnt);
    checkOutput("pa_sync_disabled_count", LW'(cnt), LW'(0));
    enable = 1'b1;

    // Basic 8-cycle frame from the stream
    applyStimulus(1, 1'b0, 32'd8, 32'hA5A5_0001, 1'b1, 1'b0);

    // rs256 outside the window is ignored
    waitFt(8'd100);
    waitFt(8'd5);
    rs256 = 1'b1;
    waitFt(8'd8);
    rs256 = 1'b0;
    checkIdle("idle_after_late_trigger");

    // Long frame; a window request during DC must not restart it
    applyStimulus(1, 1'b0, 32'd300, 32'h1234_5678, 1'b1, 1'b0);
    waitFt(8'd255);
    rs0 = 1'b1;
    waitFt(8'd2);
    rs0 = 1'b0;

    // Underrun reuses the previous pattern
    applyStimulus(1, 1'b0, 32'd5, 32'h0BAD_F00D, 1'b0, 1'b0);

    // Zero length clamps to a 3-cycle frame
    applyStimulus(1, 1'b1, 32'd0, 32'hDEAD_BEEF, 1'b1, 1'b0);

    // Reset in the middle of a frame
    applyStimulus(1, 1'b0, 32'd50, 32'hCAFE_0005, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    resetChecks("midframe_reset");
    exp_frames = 32'd0; exp_underrun = 16'd0; last_word = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Three back-to-back ramp frames
    applyStimulus(3, 1'b0, 32'd256, 32'hBAD0_BAD0, 1'b1, 1'b1);

    for (int i = 0; i < 3000 && (exp_q.size() != 0 || in_frame); i++) @(negedge clk);
    checkOutput("scoreboard_drained", LW'((exp_q.size() == 0) && !in_frame), LW'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
